// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy state encodings
// and the default bubble (NOP) payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_HALF  = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush-to-bubble.
// Define PIPE_REG_SKID_EN for a 2-entry skid buffer that registers in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W = 32,
  parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != PIPE_EMPTY);
  assign out_data  = m_q;
  assign count     = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef PIPE_REG_SKID_EN
  logic [DATA_W-1:0] s_q, s_d;

  // Registered decode only: upstream never sees a path from out_ready.
  assign in_ready = (state_q != PIPE_FULL);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = PIPE_EMPTY;
      m_d     = BUBBLE;
      s_d     = BUBBLE;
    end else begin
      case (state_q)
        PIPE_EMPTY: begin
          if (in_fire) begin
            m_d     = in_data;
            state_d = PIPE_HALF;
          end
        end
        PIPE_HALF: begin
          if (in_fire && out_fire) begin
            m_d = in_data;
          end else if (in_fire) begin
            s_d     = in_data;
            state_d = PIPE_FULL;
          end else if (out_fire) begin
            m_d     = BUBBLE;
            state_d = PIPE_EMPTY;
          end
        end
        PIPE_FULL: begin
          if (out_fire) begin
            m_d     = s_q;
            s_d     = BUBBLE;
            state_d = PIPE_HALF;
          end
        end
        default: begin
          state_d = PIPE_EMPTY;
          m_d     = BUBBLE;
          s_d     = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PIPE_EMPTY;
      m_q     <= BUBBLE;
      s_q     <= BUBBLE;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end
`else
  // Single register: ready is combinational from out_ready.
  assign in_ready = ~out_valid | out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    if (flush) begin
      state_d = PIPE_EMPTY;
      m_d     = BUBBLE;
    end else if (in_fire) begin
      m_d     = in_data;
      state_d = PIPE_HALF;
    end else if (out_fire) begin
      m_d     = BUBBLE;
      state_d = PIPE_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PIPE_EMPTY;
      m_q     <= BUBBLE;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
    end
  end
`endif

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; the skid-specific section follows PIPE_REG_SKID_EN.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_stage_reg #(.DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] c);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".out_data"}, out_data, d);
    chk({tag, ".count"}, {30'd0, count}, {30'd0, c});
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    chk_out("reset", 1'b0, 32'h0, 2'd0);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    reset = 1'b1;
    step();
    step();
    chk_out("idle", 1'b0, 32'h0, 2'd0);
    chk("idle.in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming at full rate
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11;
    step(); chk_out("stream0", 1'b1, 32'h11, 2'd1);
    in_data = 32'h22;
    step(); chk_out("stream1", 1'b1, 32'h22, 2'd1);
    in_data = 32'h33;
    step(); chk_out("stream2", 1'b1, 32'h33, 2'd1);
    in_valid = 1'b0;
    step(); chk_out("stream_drain", 1'b0, 32'h0, 2'd0);

    // Simultaneous in/out with one entry held
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
    step(); chk_out("simul_load", 1'b1, 32'h5, 2'd1);
    out_ready = 1'b1; in_data = 32'h6;
    step(); chk_out("simul", 1'b1, 32'h6, 2'd1);
    in_valid = 1'b0;
    step(); chk_out("simul_drain", 1'b0, 32'h0, 2'd0);

`ifdef PIPE_REG_SKID_EN
    // Back-pressure absorbed by the skid entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step(); chk_out("bp_a", 1'b1, 32'hA, 2'd1);
    in_data = 32'hB;
    #1 chk("bp_b.in_ready_pre", {31'd0, in_ready}, 32'd1);
    step(); chk_out("bp_b", 1'b1, 32'hA, 2'd2);
    chk("bp_b.in_ready", {31'd0, in_ready}, 32'd0);
    in_data = 32'hC;
    step(); chk_out("bp_c_held", 1'b1, 32'hA, 2'd2);
    out_ready = 1'b1;
    #1 chk("bp_rel.in_ready_reg", {31'd0, in_ready}, 32'd0);
    step(); chk_out("bp_rel_b", 1'b1, 32'hB, 2'd1);
    step(); chk_out("bp_rel_c", 1'b1, 32'hC, 2'd1);
    in_valid = 1'b0;
    step(); chk_out("bp_drain", 1'b0, 32'h0, 2'd0);

    // Flush from FULL while upstream offers 0xD
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step(); chk_out("fl_full", 1'b1, 32'hA, 2'd2);
    flush = 1'b1; in_data = 32'hD;
    step(); chk_out("fl_full_flush", 1'b0, 32'h0, 2'd0);
    flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    step(); chk_out("fl_full_after", 1'b0, 32'h0, 2'd0);

    // Flush in HALF discards an accepted payload
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7;
    step();
    flush = 1'b1; in_data = 32'hE;
    step(); chk_out("fl_half", 1'b0, 32'h0, 2'd0);
    flush = 1'b0; in_valid = 1'b0;
    step(); chk_out("fl_half_after", 1'b0, 32'h0, 2'd0);
`else
    // Single-register back-pressure: ready follows out_ready combinationally
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step(); chk_out("nr_a", 1'b1, 32'hA, 2'd1);
    in_data = 32'hB;
    #1 chk("nr_stall.in_ready", {31'd0, in_ready}, 32'd0);
    step(); chk_out("nr_stall", 1'b1, 32'hA, 2'd1);
    out_ready = 1'b1;
    #1 chk("nr_rel.in_ready", {31'd0, in_ready}, 32'd1);
    step(); chk_out("nr_rel", 1'b1, 32'hB, 2'd1);
    in_valid = 1'b0;
    step(); chk_out("nr_drain", 1'b0, 32'h0, 2'd0);

    // Flush with a handshake on both sides in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    out_ready = 1'b1; flush = 1'b1; in_data = 32'hD;
    step(); chk_out("nr_flush", 1'b0, 32'h0, 2'd0);
    flush = 1'b0; in_valid = 1'b0;
    step(); chk_out("nr_flush_after", 1'b0, 32'h0, 2'd0);
`endif

    // Asynchronous reset mid-operation
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h99;
    step(); chk_out("mid_load", 1'b1, 32'h99, 2'd1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk_out("mid_reset", 1'b0, 32'h0, 2'd0);
    chk("mid_reset.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    reset = 1'b1;
    step(); step();
    chk_out("post_reset_idle", 1'b0, 32'h0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pipe_stage_reg
